// File: rtl/core_dmem_resp.sv
`default_nettype none
// ============================================================================
// core_dmem_resp : single-shot load/store responder with WAIT_CYCLES wait states.
// Optional ERR output enabled by `define DMEM_RESP_ERR_EN.  Revision: 1.0
// ============================================================================
module core_dmem_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter     INIT_FILE   = ""
) (
    input  logic        CLK,
    input  logic        NRST,
    input  logic        ISLOAD_SS,
    input  logic        ISSTORE_SS,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    input  logic [3:0]  STRB,
    input  logic        ISLOADBS,
    input  logic        ISLOADHWS,
    output logic [31:0] RDATA,
    output logic        BUSY,
    output logic        DONE
`ifdef DMEM_RESP_ERR_EN
    ,
    output logic        ERR
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    strb_q;
    logic          bs_q;
    logic          hws_q;
    logic          store_q;
    logic [31:0]   rdata_q;

    logic          w_req;
    logic          w_access;
    logic          w_wr_en;
    logic [31:0]   w_word;
    logic [31:0]   w_load;
    logic          w_unused_addr;

    assign w_req         = ISLOAD_SS | ISSTORE_SS;
    assign w_access      = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign w_word        = mem_q[idx_q];
    assign w_unused_addr = ^{ADDR[31:AW+2], ADDR[1:0]};

`ifdef DMEM_RESP_ERR_EN
    logic w_err_req;
    logic err_req_q;
    logic err_q;

    always_comb begin
        w_err_req = |ADDR[31:AW+2];
        case (STRB)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: ;
            default: w_err_req = 1'b1;
        endcase
    end

    assign w_wr_en = w_access & store_q & ~err_req_q;
    assign ERR     = err_q;
`else
    assign w_wr_en = w_access & store_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_req) begin
                    state_d = S_WAIT;
                    cnt_d   = WAIT_CYCLES[3:0];
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Lane select and extension for the latched strobe pattern.
    always_comb begin
        w_load = '0;
        case (strb_q)
            4'b1111: w_load = w_word;
            4'b0001: w_load = {{24{bs_q & w_word[7]}},   w_word[7:0]};
            4'b0010: w_load = {{24{bs_q & w_word[15]}},  w_word[15:8]};
            4'b0100: w_load = {{24{bs_q & w_word[23]}},  w_word[23:16]};
            4'b1000: w_load = {{24{bs_q & w_word[31]}},  w_word[31:24]};
            4'b0011: w_load = {{16{hws_q & w_word[15]}}, w_word[15:0]};
            4'b1100: w_load = {{16{hws_q & w_word[31]}}, w_word[31:16]};
            default: w_load = '0;
        endcase
`ifdef DMEM_RESP_ERR_EN
        if (err_req_q) w_load = '0;
`endif
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            bs_q      <= 1'b0;
            hws_q     <= 1'b0;
            store_q   <= 1'b0;
            rdata_q   <= '0;
`ifdef DMEM_RESP_ERR_EN
            err_req_q <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if ((state_q == S_IDLE) && w_req) begin
                idx_q     <= ADDR[AW+1:2];
                wdata_q   <= WDATA;
                strb_q    <= STRB;
                bs_q      <= ISLOADBS;
                hws_q     <= ISLOADHWS;
                store_q   <= ISSTORE_SS;
`ifdef DMEM_RESP_ERR_EN
                err_req_q <= w_err_req;
`endif
            end
            if (w_access && !store_q) rdata_q <= w_load;
`ifdef DMEM_RESP_ERR_EN
            if (w_access) err_q <= err_req_q;
`endif
        end
    end

    // Array is deliberately left out of reset; the write is gated by the reset FSM state.
    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (strb_q[k]) mem_q[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
            end
        end
    end

    assign RDATA = rdata_q;
    assign BUSY  = (state_q == S_WAIT);
    assign DONE  = (state_q == S_RESP);

endmodule
`default_nettype wire

// File: tb/tb_core_dmem_resp.sv
`default_nettype none
// ============================================================================
// tb_core_dmem_resp : directed scoreboard bench for core_dmem_resp.
// Revision: 1.0
// ============================================================================
module tb_core_dmem_resp;

    localparam int WAIT = 2;

    logic        CLK = 1'b0;
    logic        NRST = 1'b0;
    logic        ISLOAD_SS = 1'b0;
    logic        ISSTORE_SS = 1'b0;
    logic [31:0] ADDR = '0;
    logic [31:0] WDATA = '0;
    logic [3:0]  STRB = '0;
    logic        ISLOADBS = 1'b0;
    logic        ISLOADHWS = 1'b0;
    logic [31:0] RDATA;
    logic        BUSY;
    logic        DONE;
`ifdef DMEM_RESP_ERR_EN
    logic        ERR;
`endif

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_rd = '0;

    core_dmem_resp #(
        .DEPTH_WORDS(1024),
        .WAIT_CYCLES(WAIT),
        .INIT_FILE  ("")
    ) dut (
        .CLK       (CLK),
        .NRST      (NRST),
        .ISLOAD_SS (ISLOAD_SS),
        .ISSTORE_SS(ISSTORE_SS),
        .ADDR      (ADDR),
        .WDATA     (WDATA),
        .STRB      (STRB),
        .ISLOADBS  (ISLOADBS),
        .ISLOADHWS (ISLOADHWS),
        .RDATA     (RDATA),
        .BUSY      (BUSY),
        .DONE      (DONE)
`ifdef DMEM_RESP_ERR_EN
        ,
        .ERR       (ERR)
`endif
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle request pulse; returns at the negedge after the request edge.
    task automatic issue(input logic ld, input logic st, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] s,
                         input logic bs, input logic hws,
                         input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        @(negedge CLK);
        ISLOAD_SS  = ld;
        ISSTORE_SS = st;
        ADDR       = a;
        WDATA      = wd;
        STRB       = s;
        ISLOADBS   = bs;
        ISLOADHWS  = hws;
        e.rd  = exp_rd;
        e.err = exp_err;
        sb.push_back(e);
        last_rd = exp_rd;
        @(negedge CLK);
        ISLOAD_SS  = 1'b0;
        ISSTORE_SS = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int   lat = 0;
        exp_t e;
        chk({tag, "_busy"}, {31'd0, BUSY}, 32'd1);
        while (DONE !== 1'b1 && lat < 40) begin
            @(negedge CLK);
            lat++;
        end
        chk({tag, "_done"}, {31'd0, DONE}, 32'd1);
        chk({tag, "_lat"}, lat, WAIT + 1);
        e = sb.pop_front();
        chk({tag, "_rdata"}, RDATA, e.rd);
        chk({tag, "_busy_resp"}, {31'd0, BUSY}, 32'd0);
`ifdef DMEM_RESP_ERR_EN
        chk({tag, "_err"}, {31'd0, ERR}, {31'd0, e.err});
`endif
        @(negedge CLK);
        chk({tag, "_done_pulse"}, {31'd0, DONE}, 32'd0);
    endtask

    task automatic ld(input string tag, input logic [31:0] a, input logic [3:0] s,
                      input logic bs, input logic hws, input logic [31:0] exp_rd,
                      input logic exp_err);
        issue(1'b1, 1'b0, a, 32'h0, s, bs, hws, exp_rd, exp_err);
        wait_done(tag);
    endtask

    task automatic st(input string tag, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] s, input logic exp_err);
        issue(1'b0, 1'b1, a, wd, s, 1'b0, 1'b0, last_rd, exp_err);
        wait_done(tag);
    endtask

    initial begin
        int   done_cnt;
        exp_t e;

        repeat (3) @(negedge CLK);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        chk("rst_rdata", RDATA, 32'd0);
`ifdef DMEM_RESP_ERR_EN
        chk("rst_err", {31'd0, ERR}, 32'd0);
`endif
        NRST = 1'b1;
        @(negedge CLK);

        st("st_word",  32'h0000_0040, 32'hDEAD_BEEF, 4'b1111, 1'b0);
        ld("ld_word",  32'h0000_0040, 4'b1111, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        st("st_byte2", 32'h0000_0040, 32'h0080_0000, 4'b0100, 1'b0);
        ld("ld_b2_s",  32'h0000_0040, 4'b0100, 1'b1, 1'b0, 32'hFFFF_FF80, 1'b0);
        ld("ld_b2_u",  32'h0000_0040, 4'b0100, 1'b0, 1'b0, 32'h0000_0080, 1'b0);
        ld("ld_b3_s",  32'h0000_0040, 4'b1000, 1'b1, 1'b0, 32'hFFFF_FFDE, 1'b0);
        ld("ld_b1_s",  32'h0000_0040, 4'b0010, 1'b1, 1'b0, 32'hFFFF_FFBE, 1'b0);
        ld("ld_w_mix", 32'h0000_0040, 4'b1111, 1'b0, 1'b0, 32'hDE80_BEEF, 1'b0);

        st("st_w44",   32'h0000_0044, 32'h8001_1234, 4'b1111, 1'b0);
        ld("ld_h1_s",  32'h0000_0044, 4'b1100, 1'b0, 1'b1, 32'hFFFF_8001, 1'b0);
        ld("ld_h1_u",  32'h0000_0044, 4'b1100, 1'b0, 1'b0, 32'h0000_8001, 1'b0);
        ld("ld_h0_s",  32'h0000_0044, 4'b0011, 1'b0, 1'b1, 32'h0000_1234, 1'b0);
        ld("ld_b0_s",  32'h0000_0044, 4'b0001, 1'b1, 1'b0, 32'h0000_0034, 1'b0);
        ld("ld_bad",   32'h0000_0044, 4'b0101, 1'b0, 1'b0, 32'h0000_0000, 1'b1);

        st("st_strb0", 32'h0000_0044, 32'hFFFF_FFFF, 4'b0000, 1'b1);
        ld("ld_strb0", 32'h0000_0044, 4'b1111, 1'b0, 1'b0, 32'h8001_1234, 1'b0);

        // A store pulse during WAIT must be dropped entirely.
        issue(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'b1111, 1'b0, 1'b0, 32'hDE80_BEEF, 1'b0);
        @(negedge CLK);
        ISSTORE_SS = 1'b1;
        ADDR       = 32'h0000_0044;
        WDATA      = 32'h0000_0000;
        STRB       = 4'b1111;
        @(negedge CLK);
        ISSTORE_SS = 1'b0;
        done_cnt = 0;
        e = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            if (DONE === 1'b1) begin
                done_cnt++;
                chk("busy_ign_rdata", RDATA, e.rd);
            end
            @(negedge CLK);
        end
        chk("busy_ign_dones", done_cnt, 1);
        ld("busy_ign_mem", 32'h0000_0044, 4'b1111, 1'b0, 1'b0, 32'h8001_1234, 1'b0);

        issue(1'b1, 1'b1, 32'h0000_0048, 32'h1122_3344, 4'b1111, 1'b0, 1'b0, last_rd, 1'b0);
        wait_done("ldst_both");
        ld("ldst_mem", 32'h0000_0048, 4'b1111, 1'b0, 1'b0, 32'h1122_3344, 1'b0);

`ifdef DMEM_RESP_ERR_EN
        ld("err_oor",   32'h0001_0000, 4'b1111, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
        st("err_st",    32'h0000_0040, 32'h5555_5555, 4'b0101, 1'b1);
        ld("err_nowr",  32'h0000_0040, 4'b1111, 1'b0, 1'b0, 32'hDE80_BEEF, 1'b0);
`else
        st("wrap_st",   32'h0000_104C, 32'hCAFE_F00D, 4'b1111, 1'b0);
        ld("wrap_ld",   32'h0000_004C, 4'b1111, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b0);
`endif

        // Reset in the middle of a store: write and DONE both vanish.
        st("pre_rst_st", 32'h0000_0080, 32'hAAAA_5555, 4'b1111, 1'b0);
        @(negedge CLK);
        ISSTORE_SS = 1'b1;
        ADDR       = 32'h0000_0080;
        WDATA      = 32'h1234_5678;
        STRB       = 4'b1111;
        @(negedge CLK);
        ISSTORE_SS = 1'b0;
        @(negedge CLK);
        NRST = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, BUSY}, 32'd0);
        @(negedge CLK);
        NRST = 1'b1;
        last_rd = '0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (DONE === 1'b1) done_cnt++;
            @(negedge CLK);
        end
        chk("midrst_nodone", done_cnt, 0);
        chk("midrst_rdata", RDATA, 32'd0);
        ld("midrst_mem", 32'h0000_0080, 4'b1111, 1'b0, 1'b0, 32'hAAAA_5555, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
